// File: rtl/aes_ct_serializer.sv
// AES-128 ciphertext serializer: captures a result block on the ct_valid rising
// edge and streams it MSB byte first over an 8-bit valid/ready port.
module aes_ct_serializer #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ct_in,
    input  logic              ct_valid,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [CNT_W-1:0]  blocks_sent
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] pend;
    logic              pend_full;
    logic              ct_valid_q;
    logic              last_r;
    logic              cap;
    logic              hs;
    logic              hs_last;

    assign cap     = ct_valid & ~ct_valid_q;
    assign hs      = (state == SEND) & m_ready;
    assign hs_last = hs & (idx == LAST_IDX);

    // Active block lives in a shift register so the output byte is a flop slice.
    assign m_valid = (state == SEND);
    assign m_data  = shreg[DATA_W-1 -: 8];
    assign m_last  = last_r;
    assign busy    = m_valid | pend_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            shreg       <= '0;
            pend        <= '0;
            pend_full   <= 1'b0;
            ct_valid_q  <= 1'b0;
            last_r      <= 1'b0;
            overflow    <= 1'b0;
            blocks_sent <= '0;
        end else begin
            ct_valid_q <= ct_valid;
            if (clr_ovf) begin
                overflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cap) begin
                        shreg  <= ct_in;
                        idx    <= '0;
                        last_r <= (LAST_IDX == '0);
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (hs_last) begin
                        blocks_sent <= blocks_sent + CNT_ONE;
                        idx         <= '0;
                        last_r      <= 1'b0;
                        // Pending block takes priority; a same-cycle capture refills it.
                        if (pend_full) begin
                            shreg <= pend;
                            if (cap) begin
                                pend <= ct_in;
                            end else begin
                                pend_full <= 1'b0;
                            end
                        end else if (cap) begin
                            shreg <= ct_in;
                        end else begin
                            shreg <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        if (hs) begin
                            shreg  <= shreg << 8;
                            idx    <= idx + IDX_ONE;
                            last_r <= ((idx + IDX_ONE) == LAST_IDX);
                        end
                        if (cap) begin
                            if (pend_full) begin
                                overflow <= 1'b1;
                            end else begin
                                pend      <= ct_in;
                                pend_full <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Scoreboard bench for aes_ct_serializer: stimulus queues expected bytes,
// a negedge monitor pops and compares them on every handshake.
module tb_aes_ct_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ct_in;
    logic         ct_valid;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         busy;
    logic         overflow;
    logic         clr_ovf;
    logic [15:0]  blocks_sent;

    logic [7:0]   w_data;
    logic         w_valid;
    logic         w_last;
    logic         w_busy;
    logic         w_ovf;
    logic [3:0]   w_blocks;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int exp_blk = 0;
    logic [8:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d = 8'h00;

    localparam logic [127:0] BLK_A = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK_C = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] BLK_D = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;

    aes_ct_serializer #(.DATA_W(128), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ct_in(ct_in), .ct_valid(ct_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .overflow(overflow),
        .clr_ovf(clr_ovf), .blocks_sent(blocks_sent)
    );

    // Narrow-counter twin so the wrap of blocks_sent is reachable quickly.
    aes_ct_serializer #(.DATA_W(128), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .ct_in(ct_in), .ct_valid(ct_valid),
        .m_data(w_data), .m_valid(w_valid), .m_ready(m_ready),
        .m_last(w_last), .busy(w_busy), .overflow(w_ovf),
        .clr_ovf(clr_ovf), .blocks_sent(w_blocks)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst && stall_prev) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", {24'd0, m_data}, {24'd0, prev_d});
        end
        if (rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'd0, m_data}, 32'hffffffff);
            end else begin
                e = exp_q.pop_front();
                chk("byte", {24'd0, m_data}, {24'd0, e[7:0]});
                chk("last", {31'd0, m_last}, {31'd0, e[8]});
                if (e[8]) exp_blk++;
            end
            hs_cnt++;
        end
        stall_prev = rst && m_valid && !m_ready;
        prev_d = m_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input logic [127:0] d);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == 15), d[127-8*i -: 8]});
        end
    endtask

    task automatic pulse(input logic [127:0] d);
        ct_in = d;
        ct_valid = 1'b1;
        step();
        ct_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < 100) begin
            step();
            n++;
        end
        if (hs_cnt < target) chk("wait_hs_timeout", hs_cnt, target);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        step();
        step();
    endtask

    initial begin
        int base;
        int n;
        logic [3:0] pat;
        rst = 1'b0;
        ct_in = '0;
        ct_valid = 1'b0;
        m_ready = 1'b1;
        clr_ovf = 1'b0;
        pat = 4'b1001;
        step();
        step();
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_blocks", {16'd0, blocks_sent}, 0);
        rst = 1'b1;
        step();

        // T1: reset in the middle of a block
        push_block(BLK_A);
        pulse(BLK_A);
        wait_hs(4);
        rst = 1'b0;
        exp_q.delete();
        hs_cnt = 0;
        exp_blk = 0;
        step();
        rst = 1'b1;
        step();
        step();
        chk("t1_valid", {31'd0, m_valid}, 0);
        chk("t1_data", {24'd0, m_data}, 0);
        chk("t1_last", {31'd0, m_last}, 0);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_ovf", {31'd0, overflow}, 0);
        chk("t1_blocks", {16'd0, blocks_sent}, 0);

        // T2: single block, full-rate sink
        base = hs_cnt;
        push_block(BLK_A);
        pulse(BLK_A);
        chk("t2_lat_valid", {31'd0, m_valid}, 1);
        chk("t2_first_byte", {24'd0, m_data}, 32'h39);
        drain();
        chk("t2_hs", hs_cnt - base, 16);
        chk("t2_blocks", {16'd0, blocks_sent}, 1);
        chk("t2_idle", {31'd0, m_valid}, 0);

        // T3: backpressure pattern 1,0,0,1
        base = hs_cnt;
        push_block(BLK_A);
        pulse(BLK_A);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            m_ready = pat[n % 4];
            step();
            n++;
        end
        m_ready = 1'b1;
        step();
        step();
        chk("t3_empty", exp_q.size(), 0);
        chk("t3_hs", hs_cnt - base, 16);
        chk("t3_blocks", {16'd0, blocks_sent}, exp_blk);

        // T4: B captured at byte 5 of A, no bubble between blocks
        base = hs_cnt;
        push_block(BLK_A);
        pulse(BLK_A);
        wait_hs(base + 5);
        push_block(BLK_B);
        pulse(BLK_B);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("t4_nobubble", n, 26);
        step();
        step();
        chk("t4_hs", hs_cnt - base, 32);
        chk("t4_blocks", {16'd0, blocks_sent}, 4);

        // T5: overflow while stalled at byte 3
        base = hs_cnt;
        push_block(BLK_A);
        pulse(BLK_A);
        wait_hs(base + 3);
        m_ready = 1'b0;
        push_block(BLK_B);
        pulse(BLK_B);
        step();
        pulse(BLK_C);
        step();
        chk("t5_ovf_set", {31'd0, overflow}, 1);
        chk("t5_busy", {31'd0, busy}, 1);
        m_ready = 1'b1;
        drain();
        chk("t5_hs", hs_cnt - base, 32);
        chk("t5_ovf_sticky", {31'd0, overflow}, 1);
        chk("t5_idle_busy", {31'd0, busy}, 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t5_ovf_clr", {31'd0, overflow}, 0);

        // T6: level held 50 cycles captures once
        base = hs_cnt;
        push_block(BLK_D);
        ct_in = BLK_D;
        ct_valid = 1'b1;
        for (int i = 0; i < 50; i++) step();
        ct_valid = 1'b0;
        drain();
        chk("t6_hs", hs_cnt - base, 16);
        chk("t6_blocks", {16'd0, blocks_sent}, 7);

        // Counter wrap on the 4-bit twin
        n = 0;
        while ((exp_blk % 16) != 0 && n < 20) begin
            push_block(BLK_B);
            pulse(BLK_B);
            drain();
            n++;
        end
        chk("wrap_wide", {16'd0, blocks_sent}, 16);
        chk("wrap_narrow", {28'd0, w_blocks}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
